// File: rtl/posit_mult_pkg.sv
// posit_mult_pkg
// Shared definitions for the iterative posit multiplier:
//   - state_t      : FSM state encoding of mult_arithmetic_iter
//   - RS_DEFAULT / RO_SAT_DEFAULT : regime width and R_O saturation value
//                    for the default N=8 configuration
//   - ro_sat()     : R_O saturation constant 2^RS for any regime width
//   - calc_r_o()   : regime shift amount derived from the combined scale
package posit_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RS_DEFAULT     = 3;
  localparam int RO_SAT_DEFAULT = 1 << RS_DEFAULT;

  // Largest regime shift representable: 2^RS (only bit RS set).
  function automatic logic [31:0] ro_sat(input int rs);
    return 32'd1 << rs;
  endfunction

  // total_eo is the combined scale sign-extended to 32 bits.
  // k = total_eo >>> es; shift is -k for negative regimes, k+1 otherwise,
  // clamped to 2^rs so it always fits in rs+1 bits.
  function automatic logic [31:0] calc_r_o(input logic signed [31:0] total_eo,
                                           input int es, input int rs);
    logic signed [31:0] k;
    logic [31:0]        mag;
    k = total_eo >>> es;
    if (k < 0) mag = -k;
    else       mag = k + 1;
    if (mag > ro_sat(rs)) mag = ro_sat(rs);
    return mag;
  endfunction

endpackage

// File: rtl/mult_arithmetic_iter_shift_add_mult.sv
// shift_add_mult
// Radix-2 shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : load operands, clear accumulator and counter
//   mcand, mplier   : N-bit unsigned operands (sampled on start)
//   busy            : iterations in progress
//   last            : current cycle performs the final iteration
//   acc_next        : accumulator value after this cycle's iteration;
//                     equals the full product while last is high
module shift_add_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           last,
  output logic [2*N-1:0] acc_next
);
  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  assign last     = busy_q && (cnt_q == CW'(N - 1));
  assign busy     = busy_q;
  assign acc_next = acc_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{N{1'b0}}, mcand};
      mplier_d = mplier;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      // Multiplicand moves left while the multiplier moves right, so the
      // current multiplier bit is always bit 0.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/mult_arithmetic_iter.sv
// mult_arithmetic_iter
// Iterative posit multiply stage feeding the Rounding stage. Captures a
// decoded operand pair, multiplies mantissas over N cycles, normalises the
// product and forms the combined scale, regime shift and exponent.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   S*, R*, E*, M*        : operand sign, regime k, exponent, mantissa
//   inf*, zero*           : operand special flags
//   out_valid / out_ready : result handshake (held stable while stalled)
//   Mult_Mant_N           : normalised product, leading one at MSB
//   Total_EO, E_O, R_O    : combined scale, result exponent, regime shift
//   inf, zero, Operation  : special result flags and result sign
module mult_arithmetic_iter
  import posit_mult_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int RS = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              S1,
  input  logic              S2,
  input  logic [RS:0]       R1,
  input  logic [RS:0]       R2,
  input  logic [ES-1:0]     E1,
  input  logic [ES-1:0]     E2,
  input  logic [N-1:0]      M1,
  input  logic [N-1:0]      M2,
  input  logic              inf1,
  input  logic              inf2,
  input  logic              zero1,
  input  logic              zero2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-1:0]    Mult_Mant_N,
  output logic [RS+ES+1:0]  Total_EO,
  output logic [ES-1:0]     E_O,
  output logic [RS:0]       R_O,
  output logic              inf,
  output logic              zero,
  output logic              Operation
);
  localparam int TW = RS + ES + 2;

  state_t state_q, state_d;

  // Captured operand fields (mantissas live inside the multiplier).
  logic          sign_q, sign_d;
  logic [RS:0]   r1_q, r1_d, r2_q, r2_d;
  logic [ES-1:0] e1_q, e1_d, e2_q, e2_d;
  logic          inf_in_q, inf_in_d, zero_in_q, zero_in_d;

  // Result registers.
  logic [2*N-1:0] mant_q, mant_d;
  logic [TW-1:0]  total_q, total_d;
  logic [ES-1:0]  e_o_q, e_o_d;
  logic [RS:0]    r_o_q, r_o_d;
  logic           inf_q, inf_d, zero_q, zero_d, op_q, op_d;

  logic           accept, special_in, mult_start;
  logic           mult_busy, mult_last;
  logic [2*N-1:0] product;
  logic           ovf;
  logic [TW-1:0]  r1_ext, r2_ext, total_sum;
  logic [31:0]    total_ext;

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign special_in = inf1 | inf2 | zero1 | zero2;
  assign mult_start = accept && !special_in;

  shift_add_mult #(.N(N)) u_mult (
    .clk      (clk),
    .rst      (reset),
    .start    (mult_start),
    .mcand    (M1),
    .mplier   (M2),
    .busy     (mult_busy),
    .last     (mult_last),
    .acc_next (product)
  );

  // Scale arithmetic works from captured fields and the final product only.
  assign ovf       = product[2*N-1];
  assign r1_ext    = {{(TW-RS-1){r1_q[RS]}}, r1_q};
  assign r2_ext    = {{(TW-RS-1){r2_q[RS]}}, r2_q};
  assign total_sum = (r1_ext << ES) + TW'(e1_q) + (r2_ext << ES) + TW'(e2_q)
                   + {{(TW-1){1'b0}}, ovf};
  assign total_ext = {{(32-TW){total_sum[TW-1]}}, total_sum};

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    e1_d      = e1_q;
    e2_d      = e2_q;
    inf_in_d  = inf_in_q;
    zero_in_d = zero_in_q;
    mant_d    = mant_q;
    total_d   = total_q;
    e_o_d     = e_o_q;
    r_o_d     = r_o_q;
    inf_d     = inf_q;
    zero_d    = zero_q;
    op_d      = op_q;

    case (state_q)
      IDLE: if (accept) state_d = MUL;
      MUL: begin
        if (inf_in_q || zero_in_q) begin
          // Specials bypass the iteration loop and finish after one cycle.
          state_d = DONE;
          mant_d  = '0;
          total_d = '0;
          e_o_d   = '0;
          r_o_d   = '0;
          inf_d   = inf_in_q;
          zero_d  = !inf_in_q && zero_in_q;
          op_d    = sign_q;
        end else if (mult_last) begin
          state_d = DONE;
          mant_d  = ovf ? product : {product[2*N-2:0], 1'b0};
          total_d = total_sum;
          e_o_d   = total_sum[ES-1:0];
          r_o_d   = (RS+1)'(calc_r_o(total_ext, ES, RS));
          inf_d   = 1'b0;
          zero_d  = 1'b0;
          op_d    = sign_q;
        end
      end
      DONE: if (out_ready) state_d = accept ? MUL : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sign_d    = S1 ^ S2;
      r1_d      = R1;
      r2_d      = R2;
      e1_d      = E1;
      e2_d      = E2;
      inf_in_d  = inf1 | inf2;
      zero_in_d = zero1 | zero2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      r1_q      <= '0;
      r2_q      <= '0;
      e1_q      <= '0;
      e2_q      <= '0;
      inf_in_q  <= 1'b0;
      zero_in_q <= 1'b0;
      mant_q    <= '0;
      total_q   <= '0;
      e_o_q     <= '0;
      r_o_q     <= '0;
      inf_q     <= 1'b0;
      zero_q    <= 1'b0;
      op_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      inf_in_q  <= inf_in_d;
      zero_in_q <= zero_in_d;
      mant_q    <= mant_d;
      total_q   <= total_d;
      e_o_q     <= e_o_d;
      r_o_q     <= r_o_d;
      inf_q     <= inf_d;
      zero_q    <= zero_d;
      op_q      <= op_d;
    end
  end

  // busy is informational here; the FSM tracks the loop via last.
  logic unused_busy;
  assign unused_busy = mult_busy;

  assign out_valid   = (state_q == DONE);
  assign Mult_Mant_N = mant_q;
  assign Total_EO    = total_q;
  assign E_O         = e_o_q;
  assign R_O         = r_o_q;
  assign inf         = inf_q;
  assign zero        = zero_q;
  assign Operation   = op_q;

endmodule
